// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared encodings for the hardwired control sequencer.
// Holds the FSM state codes, the ALU operation codes and the opcode class enum.
// The PAUSE state only exists when the design is built with SINGLE_STEP_EN.
package ctrl_pkg;

  // State codes; the low three bits are what the debug T_STATE port shows.
  // PAUSE is 8 so that its debug code folds onto 0 while staying distinct.
  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_T0     = 4'd1,
    ST_T1     = 4'd2,
    ST_T2     = 4'd3,
    ST_T3     = 4'd4,
    ST_T4     = 4'd5,
    ST_T5     = 4'd6,
    ST_HALTED = 4'd7,
    ST_PAUSE  = 4'd8
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SHL = 3'd4;
  localparam logic [2:0] ALU_XOR = 3'd5;

  typedef enum logic [1:0] {
    CLS_LD   = 2'd0,
    CLS_ALU  = 2'd1,
    CLS_HALT = 2'd2,
    CLS_NOP  = 2'd3
  } opclass_t;

  // Debug code shown on T_STATE for a given state.
  function automatic logic [2:0] debug_code(input state_t s);
    logic [3:0] raw;
    raw = s;
    return raw[2:0];
  endfunction

endpackage

// File: rtl/opcode_class_enc.sv
// opcode_class_enc: folds the eight one-hot decode lines into an opcode class
// and an ALU code. Anything that is not exactly one-hot is flagged illegal and
// classed as NOP. Line order in op_lines: [7]=LD [6]=ADD [5]=SUB [4]=AND
// [3]=OR [2]=SHL [1]=XOR [0]=HALT.
module opcode_class_enc
  import ctrl_pkg::*;
(
  input  logic [7:0] op_lines,
  output opclass_t   cls,
  output logic [2:0] alu_code,
  output logic       illegal
);

  // Pure lookup: one legal pattern per opcode, everything else is a NOP.
  always_comb begin
    cls      = CLS_NOP;
    alu_code = ALU_ADD;
    illegal  = 1'b0;
    case (op_lines)
      8'b1000_0000: cls = CLS_LD;
      8'b0100_0000: begin cls = CLS_ALU; alu_code = ALU_ADD; end
      8'b0010_0000: begin cls = CLS_ALU; alu_code = ALU_SUB; end
      8'b0001_0000: begin cls = CLS_ALU; alu_code = ALU_AND; end
      8'b0000_1000: begin cls = CLS_ALU; alu_code = ALU_OR;  end
      8'b0000_0100: begin cls = CLS_ALU; alu_code = ALU_SHL; end
      8'b0000_0010: begin cls = CLS_ALU; alu_code = ALU_XOR; end
      8'b0000_0001: cls = CLS_HALT;
      default:      illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: Moore control unit stepping each instruction through
// fetch (T0/T1), decode (T2) and execute (T3..T5).
// Optional macro SINGLE_STEP_EN adds a STEP input and a PAUSE state entered
// after every retire; a rising edge on STEP resumes at T0.
module ctrl_sequencer
  import ctrl_pkg::*;
#(
  parameter int ICNT_W  = 8,
  parameter int ALUOP_W = 3
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               START,
`ifdef SINGLE_STEP_EN
  input  logic               STEP,
`endif
  input  logic               LD,
  input  logic               ADD,
  input  logic               SUB,
  input  logic               AND,
  input  logic               OR,
  input  logic               SHL,
  input  logic               XOR,
  input  logic               HALT,
  output logic               IIR,
  output logic               IPC,
  output logic               EMAR,
  output logic               ERAM,
  output logic               IA,
  output logic               IB,
  output logic               ESUM,
  output logic [ALUOP_W-1:0] ALU_OP,
  output logic               RUN,
  output logic [2:0]         T_STATE,
  output logic [ICNT_W-1:0]  INSTR_CNT
);

  state_t     state_q;
  state_t     state_d;
  state_t     resume_state;
  opclass_t   cls;
  opclass_t   cls_q;
  logic [2:0] alu_code;
  logic [2:0] alu_q;
  logic       illegal;
  logic       retire;
  logic       step_rise;

  opcode_class_enc u_enc (
    .op_lines ({LD, ADD, SUB, AND, OR, SHL, XOR, HALT}),
    .cls      (cls),
    .alu_code (alu_code),
    .illegal  (illegal)
  );

`ifdef SINGLE_STEP_EN
  logic step_q;

  // Remember last STEP level so only a rising edge releases PAUSE.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) step_q <= 1'b0;
    else        step_q <= STEP;
  end

  assign step_rise    = STEP & ~step_q;
  assign resume_state = ST_PAUSE;
`else
  assign step_rise    = 1'b0;
  assign resume_state = ST_T0;
`endif

  // State register; reset abandons any instruction in flight.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Capture the opcode class at the end of decode so later IR changes are ignored.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cls_q <= CLS_NOP;
      alu_q <= ALU_ADD;
    end else if (state_q == ST_T2) begin
      cls_q <= cls;
      alu_q <= (cls == CLS_ALU) ? alu_code : ALU_ADD;
    end
  end

  // Retired-instruction counter, free-running wrap.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)      INSTR_CNT <= '0;
    else if (retire) INSTR_CNT <= INSTR_CNT + ICNT_W'(1);
  end

  // Next-state and retire decision; retire marks the last state of an instruction.
  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      ST_IDLE: if (START) state_d = ST_T0;
      ST_T0:   state_d = ST_T1;
      ST_T1:   state_d = ST_T2;
      ST_T2: begin
        if (illegal || cls == CLS_NOP) begin
          retire  = 1'b1;
          state_d = resume_state;
        end else if (cls == CLS_HALT) begin
          retire  = 1'b1;
          state_d = ST_HALTED;
        end else begin
          state_d = ST_T3;
        end
      end
      ST_T3:   state_d = ST_T4;
      ST_T4: begin
        if (cls_q == CLS_LD) begin
          retire  = 1'b1;
          state_d = resume_state;
        end else begin
          state_d = ST_T5;
        end
      end
      ST_T5: begin
        retire  = 1'b1;
        state_d = resume_state;
      end
      ST_HALTED: state_d = ST_HALTED;
      ST_PAUSE:  if (step_rise) state_d = ST_T0;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Moore strobe decode from the registered state and latched class.
  always_comb begin
    IIR     = 1'b0;
    IPC     = 1'b0;
    EMAR    = 1'b0;
    ERAM    = 1'b0;
    IA      = 1'b0;
    IB      = 1'b0;
    ESUM    = 1'b0;
    ALU_OP  = '0;
    RUN     = (state_q != ST_IDLE) && (state_q != ST_HALTED);
    T_STATE = debug_code(state_q);
    case (state_q)
      ST_T0: EMAR = 1'b1;
      ST_T1: begin
        ERAM = 1'b1;
        IIR  = 1'b1;
        IPC  = 1'b1;
      end
      ST_T3: EMAR = 1'b1;
      ST_T4: begin
        ERAM = 1'b1;
        IPC  = 1'b1;
        IA   = (cls_q == CLS_LD);
        IB   = (cls_q == CLS_ALU);
      end
      ST_T5: begin
        ESUM = 1'b1;
        IA   = 1'b1;
      end
      default: ;
    endcase
    if ((state_q == ST_T3 || state_q == ST_T4 || state_q == ST_T5) && cls_q == CLS_ALU)
      ALU_OP = ALUOP_W'(alu_q);
  end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// tb_ctrl_sequencer: randomized and directed checks of ctrl_sequencer against an
// instruction-level timeline model. Counter width is reduced to 2 so wrap is hit often.
module tb_ctrl_sequencer;

  localparam int CW   = 2;
  localparam int ALUW = 3;

  logic CLK = 1'b0;
  logic RST_N, START;
  logic LD, ADD, SUB, AND, OR, SHL, XOR, HALT;
`ifdef SINGLE_STEP_EN
  logic STEP;
`endif
  logic IIR, IPC, EMAR, ERAM, IA, IB, ESUM, RUN;
  logic [ALUW-1:0] ALU_OP;
  logic [2:0]      T_STATE;
  logic [CW-1:0]   INSTR_CNT;
  logic [6:0]      strobes;

  int compared   = 0;
  int mismatched = 0;

  // model: mode 0 idle, 1 running, 2 halted, 3 paused; pos = cycle within instruction
  int          mMode;
  int          mPos;
  int          mCls;
  logic [2:0]  mAlu;
  logic [CW-1:0] mCnt;
  logic        mPrevStep;

  ctrl_sequencer #(.ICNT_W(CW), .ALUOP_W(ALUW)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START),
`ifdef SINGLE_STEP_EN
    .STEP(STEP),
`endif
    .LD(LD), .ADD(ADD), .SUB(SUB), .AND(AND), .OR(OR), .SHL(SHL), .XOR(XOR), .HALT(HALT),
    .IIR(IIR), .IPC(IPC), .EMAR(EMAR), .ERAM(ERAM), .IA(IA), .IB(IB), .ESUM(ESUM),
    .ALU_OP(ALU_OP), .RUN(RUN), .T_STATE(T_STATE), .INSTR_CNT(INSTR_CNT)
  );

  always #5 CLK = ~CLK;

  assign strobes = {IIR, IPC, EMAR, ERAM, IA, IB, ESUM};

  task automatic cmp(input string nm, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mMode = 0; mPos = 0; mCls = 3; mAlu = 3'd0; mCnt = '0; mPrevStep = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic modelStep(input logic [7:0] lines, input logic st, input logic stp);
    int last;
    case (mMode)
      0: if (st) begin mMode = 1; mPos = 0; end
      1: begin
        if (mPos == 2) begin
          mAlu = 3'd0;
          if ($countones(lines) != 1) mCls = 3;
          else if (lines[7])          mCls = 0;
          else if (lines[0])          mCls = 2;
          else begin
            mCls = 1;
            for (int k = 1; k <= 6; k++) if (lines[k]) mAlu = 3'(6 - k);
          end
        end
        last = (mCls == 0) ? 4 : (mCls == 1) ? 5 : 2;
        if (mPos >= 2 && mPos == last) begin
          mCnt = mCnt + 1'b1;
          if (mCls == 2) mMode = 2;
          else begin
`ifdef SINGLE_STEP_EN
            mMode = 3;
`else
            mPos = 0;
`endif
          end
        end else begin
          mPos = mPos + 1;
        end
      end
      3: if (stp && !mPrevStep) begin mMode = 1; mPos = 0; end
      default: ;
    endcase
    mPrevStep = stp;
  endtask

  // Compare all DUT outputs against what the model says this cycle must show.
  task automatic checkOutput();
    logic [6:0] es;
    int ets, ealu;
    es = 7'b0;
    ealu = 0;
    ets = (mMode == 2) ? 7 : (mMode == 1) ? mPos + 1 : 0;
    if (mMode == 1) begin
      case (mPos)
        0: es = 7'b0010000;
        1: es = 7'b1101000;
        3: es = 7'b0010000;
        4: es = (mCls == 0) ? 7'b0101100 : 7'b0101010;
        5: es = 7'b0000101;
        default: es = 7'b0;
      endcase
      if (mPos >= 3 && mCls == 1) ealu = mAlu;
    end
    cmp("strobes", strobes, es);
    cmp("alu_op", ALU_OP, ealu);
    cmp("run", RUN, (mMode == 1 || mMode == 3) ? 1 : 0);
    cmp("t_state", T_STATE, ets);
    cmp("instr_cnt", INSTR_CNT, mCnt);
  endtask

  // One cycle: check at negedge, drive, advance model, move to next negedge.
  task automatic applyStimulus(input logic st, input logic [7:0] lines, input logic stp);
    checkOutput();
    START = st;
    {LD, ADD, SUB, AND, OR, SHL, XOR, HALT} = lines;
`ifdef SINGLE_STEP_EN
    STEP = stp;
`endif
    modelStep(lines, st, stp);
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // Asynchronous reset in the middle of a cycle; outputs must clear at once.
  task automatic applyReset();
    #2 RST_N = 1'b0;
    #1;
    cmp("rst_strobes", strobes, 0);
    cmp("rst_tstate", T_STATE, 0);
    cmp("rst_cnt", INSTR_CNT, 0);
    cmp("rst_run", RUN, 0);
    modelReset();
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  // Run one instruction to retire, noting its running-cycle count and datapath strobes.
  task automatic runInstr(input logic [7:0] lines, output int cycles, output logic sawIa,
                          output logic sawIb, output logic sawEsum, output int aluAtEsum);
    logic [CW-1:0] c0;
    logic done;
    c0 = mCnt; cycles = 0; done = 1'b0;
    sawIa = 0; sawIb = 0; sawEsum = 0; aluAtEsum = -1;
    for (int i = 0; i < 40 && !done; i++) begin
      if (mMode == 1) cycles++;
      if (IA) sawIa = 1;
      if (IB) sawIb = 1;
      if (ESUM) begin sawEsum = 1; aluAtEsum = ALU_OP; end
      applyStimulus(1'b1, lines, i[0]);
      if (mCnt != c0) done = 1'b1;
    end
    if (!done) begin
      compared++; mismatched++;
      $display("[TB] FAIL instr_timeout: got no retire, expected retire within 40 cycles");
    end
  endtask

  function automatic logic [7:0] randLines();
    int r;
    r = $urandom_range(19);
    if (r < 13)      return 8'b0000_0010 << $urandom_range(6);
    else if (r < 14) return 8'b0000_0001;
    else if (r < 17) return 8'b0;
    else             return 8'($urandom);
  endfunction

  initial begin
    int cyc, aluE, haltRun;
    logic a, b, e;
    RST_N = 1'b0; START = 1'b0;
    {LD, ADD, SUB, AND, OR, SHL, XOR, HALT} = 8'b0;
`ifdef SINGLE_STEP_EN
    STEP = 1'b0;
`endif
    modelReset();
    repeat (2) @(negedge CLK);
    checkOutput();
    RST_N = 1'b1;

    // LD: 5 cycles, IA at T4, count 1
    runInstr(8'b1000_0000, cyc, a, b, e, aluE);
    cmp("ld_cycles", cyc, 5);
    cmp("ld_ia", a, 1);
    cmp("ld_ib", b, 0);
    cmp("cnt_after_ld", INSTR_CNT, 1);
    // SUB: 6 cycles, IB at T4, ALU_OP=1 with ESUM
    runInstr(8'b0010_0000, cyc, a, b, e, aluE);
    cmp("sub_cycles", cyc, 6);
    cmp("sub_ib", b, 1);
    cmp("sub_aluop", aluE, 1);
    cmp("cnt_after_sub", INSTR_CNT, 2);
    // NOPs: zero-hot then ADD|XOR
    runInstr(8'b0, cyc, a, b, e, aluE);
    cmp("nop0_cycles", cyc, 3);
    cmp("nop0_datapath", {a, b, e}, 0);
    cmp("cnt_after_nop0", INSTR_CNT, 3);
    runInstr(8'b0100_0010, cyc, a, b, e, aluE);
    cmp("nop2_cycles", cyc, 3);
    cmp("nop2_datapath", {a, b, e}, 0);
    cmp("cnt_wrap", INSTR_CNT, 0);
    runInstr(8'b1000_0000, cyc, a, b, e, aluE);
    cmp("cnt_after_wrap", INSTR_CNT, 1);
    // HALT: 3 cycles then stuck with START toggling
    runInstr(8'b0000_0001, cyc, a, b, e, aluE);
    cmp("halt_cycles", cyc, 3);
    for (int i = 0; i < 20; i++) applyStimulus(i[0], randLines(), i[1]);
    cmp("halted_tstate", T_STATE, 7);
    cmp("halted_run", RUN, 0);
    cmp("halted_cnt", INSTR_CNT, 2);

    // Asynchronous reset in the middle of T4 of an LD
    applyReset();
    for (int i = 0; i < 20 && !(mMode == 1 && mPos == 4); i++)
      applyStimulus(1'b1, 8'b1000_0000, i[0]);
    cmp("pre_rst_t4", T_STATE, 5);
    applyReset();

    // Randomized run with occasional async resets and halt recovery
    haltRun = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(299) == 0 || haltRun > 12) begin
        applyReset();
        haltRun = 0;
      end
      applyStimulus(($urandom_range(3) != 0), randLines(), 1'($urandom));
      haltRun = (mMode == 2) ? haltRun + 1 : 0;
    end
    checkOutput();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before 2000000");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
